// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the datapath
// that consumes its per-stage controls.
package pipe_ctrl_pkg;

    localparam int W_DATA = 32;

    localparam logic PCTL_RUN   = 1'b0;
    localparam logic PCTL_REDIR = 1'b1;

    typedef enum logic {
        ST_RUN   = PCTL_RUN,
        ST_REDIR = PCTL_REDIR
    } pctl_state_e;

    // One bundle of hold/bubble controls for the five pipeline stage registers.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
    } stage_ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: counts enabled cycles, wraps at 2^W_DATA.
// Shared by the stall-cycle counter and future CP0 counters.
module perf_counter
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [W_DATA-1:0] count
);

    logic [W_DATA-1:0] count_q;
    logic [W_DATA-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W_DATA'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: prioritises stage stall requests, applies
// exception flushes and holds the registered exception redirect for IF.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_stall,
    input  logic              load_use,
    input  logic              ex_req_stall,
    input  logic              mem_req_stall,
    input  logic              exc_flush,
    input  logic [W_DATA-1:0] exc_target,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              stall_wb,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              redirect_valid,
    output logic [W_DATA-1:0] redirect_pc,
    output logic [W_DATA-1:0] stall_cycles
);

    pctl_state_e       state_q;
    pctl_state_e       state_d;
    logic [W_DATA-1:0] redirect_pc_q;
    logic [W_DATA-1:0] redirect_pc_d;
    stage_ctrl_t       ctrl;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next state; a newer exception always replaces the pending target.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        if (exc_flush) begin
            redirect_pc_d = exc_target;
        end
        case (state_q)
            ST_RUN: begin
                if (exc_flush) begin
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (!exc_flush && !if_req_stall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // EX handshake: ex_req_stall is the unit's "not ready"; stall_ex is its
    // hold (asserted for any cause at or below EX, including downstream MEM)
    // and flush_ex is its abort. The unit may only retire when stall_ex is 0.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (exc_flush) begin
                        ctrl.flush_id  = 1'b1;
                        ctrl.flush_ex  = 1'b1;
                        ctrl.flush_mem = 1'b1;
                    end else if (mem_req_stall) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.stall_mem = 1'b1;
                        ctrl.flush_wb  = 1'b1;
                    end else if (ex_req_stall) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.flush_mem = 1'b1;
                    end else if (load_use) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.flush_ex  = 1'b1;
                    end else if (if_req_stall) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.flush_id  = 1'b1;
                    end
                end
                ST_REDIR: begin
                    // Wrong-path work is squashed until IF takes the redirect.
                    ctrl.stall_if  = if_req_stall;
                    ctrl.flush_id  = 1'b1;
                    ctrl.flush_ex  = 1'b1;
                    ctrl.flush_mem = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign stall_if       = ctrl.stall_if;
    assign stall_id       = ctrl.stall_id;
    assign stall_ex       = ctrl.stall_ex;
    assign stall_mem      = ctrl.stall_mem;
    assign stall_wb       = ctrl.stall_wb;
    assign flush_id       = ctrl.flush_id;
    assign flush_ex       = ctrl.flush_ex;
    assign flush_mem      = ctrl.flush_mem;
    assign flush_wb       = ctrl.flush_wb;
    assign redirect_valid = !rst && (state_q == ST_REDIR);
    assign redirect_pc    = redirect_pc_q;

    perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.stall_if),
        .count (stall_cycles)
    );

endmodule
